// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses as {rd,sel}, exception codes,
// Status/Cause bit positions and redirect FSM encoding.
package cp0_pkg;

    localparam logic [7:0] CP0_BADVADDR = 8'h40;
    localparam logic [7:0] CP0_COUNT    = 8'h48;
    localparam logic [7:0] CP0_COMPARE  = 8'h58;
    localparam logic [7:0] CP0_STATUS   = 8'h60;
    localparam logic [7:0] CP0_CAUSE    = 8'h68;
    localparam logic [7:0] CP0_EPC      = 8'h70;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int ST_BEV    = 22;
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_HOLD = 1'b1
    } rd_state_t;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a COUNT_DIV prescaler; TI latches when Count steps onto Compare.
// Only built when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;
    logic          tick;

    always_comb begin
        tick      = (presc_q == PW'(COUNT_DIV - 1));
        presc_d   = tick ? '0 : presc_q + PW'(1);
        count_d   = tick ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (tick && !count_we && (count_q + 32'd1 == compare_q)) begin
            ti_d = 1'b1;
        end
        // A software Count load restarts the prescaler phase
        if (count_we) begin
            count_d = wdata;
            presc_d = '0;
        end
        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule
`endif

// File: rtl/cp0_unit.sv
// CP0 beside write-back: exception/interrupt/ERET commit, interrupt sync, redirect hold until fetch ack.
// Timer (Count/Compare/TI) present only when CP0_TIMER_EN is defined.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT  = 6,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'hbfc00380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [31:0]           wb_pc,
    input  logic                  wb_bd,
    input  logic                  wb_exc,
    input  logic [4:0]            wb_exc_code,
    input  logic [31:0]           wb_badvaddr,
    input  logic                  wb_eret,
    input  logic                  wb_mtc0,
    input  logic [7:0]            cp0_addr,
    input  logic [31:0]           cp0_wdata,
    output logic [31:0]           cp0_rdata,
    input  logic [NUM_HW_INT-1:0] ext_int,
    output logic                  int_take,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    input  logic                  redirect_ack,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);
    logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];
    logic [NUM_HW_INT-1:0] sync_d [SYNC_STAGES];

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    rd_state_t   state_q, state_d;
    logic [31:0] rpc_q, rpc_d;

    logic [5:0]  ip_hw;
    logic [7:0]  ip;
    logic        ti;
    logic [31:0] count_val, compare_val;
    logic        pend, fire, evt, exc_evt, eret_evt, mtc0_evt;
    logic [31:0] status_val, cause_val;

    always_comb begin
        sync_d[0] = ext_int;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        ip_hw = '0;
        ip_hw[NUM_HW_INT-1:0] = sync_q[SYNC_STAGES-1];
    end

    assign ip   = {ip_hw[5] | ti, ip_hw[4:0], ip_sw_q};
    assign pend = ie_q & ~exl_q & (|(im_q & ip));

    // While holding a redirect the WB slot is dead, so nothing may commit
    assign fire     = wb_valid & (state_q == RD_IDLE) & ~reset;
    assign int_take = fire & pend;
    assign exc_evt  = fire & wb_exc & ~pend;
    assign eret_evt = fire & wb_eret & ~pend & ~wb_exc;
    assign mtc0_evt = fire & wb_mtc0 & ~pend & ~wb_exc & ~wb_eret;
    assign evt      = int_take | exc_evt;

    assign flush          = evt | eret_evt;
    assign redirect_valid = flush | (state_q == RD_HOLD);
    assign redirect_pc    = (state_q == RD_HOLD) ? rpc_q :
                            eret_evt           ? epc_q :
                            evt                ? EXC_VECTOR : 32'd0;

`ifdef CP0_TIMER_EN
    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (mtc0_evt && (cp0_addr == CP0_COUNT)),
        .compare_we (mtc0_evt && (cp0_addr == CP0_COMPARE)),
        .wdata      (cp0_wdata),
        .count      (count_val),
        .compare    (compare_val),
        .ti         (ti)
    );
`else
    assign count_val   = 32'd0;
    assign compare_val = 32'd0;
    assign ti          = 1'b0;
`endif

    always_comb begin
        status_val                   = '0;
        status_val[ST_BEV]           = 1'b1;
        status_val[ST_IM_LO +: 8]    = im_q;
        status_val[ST_EXL]           = exl_q;
        status_val[ST_IE]            = ie_q;
        cause_val                    = '0;
        cause_val[CA_BD]             = bd_q;
        cause_val[CA_TI]             = ti;
        cause_val[CA_IP_LO +: 8]     = ip;
        cause_val[CA_EXC_LO +: 5]    = exc_code_q;
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        ip_sw_d    = ip_sw_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        if (evt) begin
            exc_code_d = int_take ? EXC_INT : wb_exc_code;
            // Nested events keep the original return point
            if (!exl_q) begin
                epc_d = wb_bd ? wb_pc - 32'd4 : wb_pc;
                bd_d  = wb_bd;
            end
            exl_d = 1'b1;
            if (exc_evt && is_addr_exc(wb_exc_code)) begin
                badvaddr_d = wb_badvaddr;
            end
        end else if (eret_evt) begin
            exl_d = 1'b0;
        end else if (mtc0_evt) begin
            case (cp0_addr)
                CP0_STATUS: begin
                    im_d  = cp0_wdata[ST_IM_LO +: 8];
                    exl_d = cp0_wdata[ST_EXL];
                    ie_d  = cp0_wdata[ST_IE];
                end
                CP0_CAUSE: ip_sw_d = cp0_wdata[CA_IP_LO +: 2];
                CP0_EPC:   epc_d   = cp0_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        rpc_d   = rpc_q;
        if (state_q == RD_HOLD) begin
            if (redirect_ack) state_d = RD_IDLE;
        end else if (flush && !redirect_ack) begin
            state_d = RD_HOLD;
            rpc_d   = redirect_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            ip_sw_q    <= '0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            ip_sw_q    <= ip_sw_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RD_IDLE;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            rpc_q   <= rpc_d;
        end
    end

    always_comb begin
        case (cp0_addr)
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_COUNT:    cp0_rdata = count_val;
            CP0_COMPARE:  cp0_rdata = compare_val;
            CP0_STATUS:   cp0_rdata = status_val;
            CP0_CAUSE:    cp0_rdata = cause_val;
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign status_o = status_val;
    assign cause_o  = cause_val;
    assign epc_o    = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios then random WB traffic, every cycle compared
// against a register-level reference model of the CP0 rules.
module tb_cp0_unit;
    localparam int          NHW = 6;
    localparam int          DIV = 2;
    localparam int          SS  = 2;
    localparam logic [31:0] VEC = 32'hbfc00380;

    logic           clk = 1'b0;
    logic           reset;
    logic           wb_valid, wb_bd, wb_exc, wb_eret, wb_mtc0, redirect_ack;
    logic [31:0]    wb_pc, wb_badvaddr, cp0_wdata;
    logic [4:0]     wb_exc_code;
    logic [7:0]     cp0_addr;
    logic [NHW-1:0] ext_int;
    logic [31:0]    cp0_rdata, redirect_pc, status_o, cause_o, epc_o;
    logic           int_take, flush, redirect_valid;

    cp0_unit #(.NUM_HW_INT(NHW), .COUNT_DIV(DIV), .EXC_VECTOR(VEC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_bd(wb_bd),
        .wb_exc(wb_exc), .wb_exc_code(wb_exc_code), .wb_badvaddr(wb_badvaddr),
        .wb_eret(wb_eret), .wb_mtc0(wb_mtc0), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .cp0_rdata(cp0_rdata), .ext_int(ext_int), .int_take(int_take), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ack(redirect_ack),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int rv_cnt   = 0;

    logic [7:0] addr_tab [8] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h00, 8'h49};
    logic [4:0] code_tab [6] = '{5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

    // Reference model state
    logic        m_ie, m_exl, m_bd, m_ti, m_hold;
    logic [7:0]  m_im;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_bva, m_count, m_compare, m_rpc;
    int          m_div;
    logic [5:0]  m_hist [SS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_hold = 0;
        m_im = 0; m_ipsw = 0; m_code = 0;
        m_epc = 0; m_bva = 0; m_count = 0; m_compare = 0; m_rpc = 0; m_div = 0;
        for (int i = 0; i < SS; i++) m_hist[i] = 0;
    endtask

    function automatic logic [7:0] m_ip();
        return ({m_hist[SS-1], 2'b00} | {6'd0, m_ipsw}) | {m_ti, 7'd0};
    endfunction

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'h40: return m_bva;
            8'h48: return m_count;
            8'h58: return m_compare;
            8'h60: return m_status();
            8'h68: return m_cause();
            8'h70: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle_inputs();
        wb_valid = 0; wb_exc = 0; wb_eret = 0; wb_mtc0 = 0; wb_bd = 0;
        wb_pc = $urandom & 32'hffff_fffc; wb_exc_code = 0; wb_badvaddr = $urandom;
        cp0_addr = addr_tab[$urandom_range(0, 7)]; cp0_wdata = $urandom; redirect_ack = 1;
    endtask

    // Called just after a falling edge with inputs applied; checks, advances one cycle.
    task automatic step();
        logic p, f, it, ex, er, mt, fl, rv;
        logic [31:0] rpc;
        #1;
        p   = m_ie & ~m_exl & (|(m_im & m_ip()));
        f   = wb_valid & ~m_hold;
        it  = f & p;
        ex  = f & wb_exc & ~p;
        er  = f & wb_eret & ~p & ~wb_exc;
        mt  = f & wb_mtc0 & ~p & ~wb_exc & ~wb_eret;
        fl  = it | ex | er;
        rv  = fl | m_hold;
        rpc = m_hold ? m_rpc : er ? m_epc : (it | ex) ? VEC : 32'd0;
        check("redirect_valid", 32'(redirect_valid), 32'(rv));
        check("redirect_pc", redirect_pc, rpc);
        check("flush", 32'(flush), 32'(fl));
        check("int_take", 32'(int_take), 32'(it));
        check("status", status_o, m_status());
        check("cause", cause_o, m_cause());
        check("epc", epc_o, m_epc);
        check("rdata", cp0_rdata, m_read(cp0_addr));
        if (redirect_valid) rv_cnt++;
        if (it | ex) begin
            m_code = it ? 5'd0 : wb_exc_code;
            if (!m_exl) begin
                m_epc = wb_bd ? wb_pc - 4 : wb_pc;
                m_bd  = wb_bd;
            end
            m_exl = 1;
            if (ex && (wb_exc_code == 4 || wb_exc_code == 5)) m_bva = wb_badvaddr;
        end
        if (er) m_exl = 0;
        if (mt && cp0_addr == 8'h60) begin
            m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0];
        end
        if (mt && cp0_addr == 8'h68) m_ipsw = cp0_wdata[9:8];
        if (mt && cp0_addr == 8'h70) m_epc = cp0_wdata;
`ifdef CP0_TIMER_EN
        if (mt && cp0_addr == 8'h48) begin
            m_count = cp0_wdata; m_div = 0;
        end else begin
            m_div++;
            if (m_div == DIV) begin
                m_div = 0; m_count++;
                if (m_count == m_compare) m_ti = 1;
            end
        end
        if (mt && cp0_addr == 8'h58) begin
            m_compare = cp0_wdata; m_ti = 0;
        end
`endif
        if (m_hold) begin
            if (redirect_ack) m_hold = 0;
        end else if (fl && !redirect_ack) begin
            m_hold = 1; m_rpc = rpc;
        end
        @(posedge clk);
        for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = 6'(ext_int);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        wb_valid = 1; wb_mtc0 = 1; cp0_addr = a; cp0_wdata = d;
        step();
    endtask

    task automatic exc(input logic [31:0] pc, input logic bd, input logic [4:0] code);
        wb_valid = 1; wb_exc = 1; wb_pc = pc; wb_bd = bd; wb_exc_code = code;
        step();
    endtask

    initial begin
        reset = 1; ext_int = 0;
        model_reset();
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'd0);
        check("rst_epc", epc_o, 32'd0);
        check("rst_rv", 32'(redirect_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        reset = 0;

        // Syscall outside delay slot
        exc(32'hbfc0_0100, 0, 5'd8);
        check("sys_epc", epc_o, 32'hbfc0_0100);
        check("sys_code", 32'(cause_o[6:2]), 32'd8);
        check("sys_exl", 32'(status_o[1]), 32'd1);

        // Delay slot with EXL clear, then again with EXL set
        mtc0(8'h60, 32'h0);
        exc(32'hbfc0_0204, 1, 5'd12);
        check("bd_epc", epc_o, 32'hbfc0_0200);
        check("bd_flag", 32'(cause_o[31]), 32'd1);
        exc(32'hbfc0_0304, 0, 5'd12);
        check("exl_epc_kept", epc_o, 32'hbfc0_0200);
        check("exl_bd_kept", 32'(cause_o[31]), 32'd1);

        // Address error records BadVAddr
        wb_badvaddr = 32'hdead_beef;
        exc(32'h0000_1000, 0, 5'd4);
        cp0_addr = 8'h40;
        step();
        check("badvaddr", m_bva, 32'hdead_beef);

        // Hardware interrupt through the synchroniser
        mtc0(8'h60, 32'h0040_0401);
        ext_int = 6'b000001;
        step();
        check("ip2_early", 32'(cause_o[10]), 32'd0);
        step();
        check("ip2_set", 32'(cause_o[10]), 32'd1);
        wb_valid = 1; wb_pc = 32'h0000_2000;
        step();
        check("int_code", 32'(cause_o[6:2]), 32'd0);
        check("int_epc", epc_o, 32'h0000_2000);
        ext_int = 0;
        step();

        // ERET held for 3 cycles without ack
        mtc0(8'h70, 32'h8000_1234);
        rv_cnt = 0;
        wb_valid = 1; wb_eret = 1; redirect_ack = 0;
        step();
        check("hold_pc", redirect_pc, 32'h8000_1234);
        wb_valid = 1; wb_exc = 1; wb_exc_code = 5'd10; redirect_ack = 0;
        step();
        wb_valid = 1; wb_mtc0 = 1; cp0_addr = 8'h70; redirect_ack = 0;
        step();
        redirect_ack = 1;
        step();
        step();
        check("hold_cycles", rv_cnt, 32'd4);
        check("eret_exl", 32'(status_o[1]), 32'd0);
        check("hold_epc", epc_o, 32'h8000_1234);

`ifdef CP0_TIMER_EN
        mtc0(8'h58, 32'd5);
        mtc0(8'h48, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            step();
            check("timer_ti", 32'(cause_o[30]), 32'(i >= 10));
        end
        check("timer_ip7", 32'(cause_o[15]), 32'd1);
        mtc0(8'h58, 32'd5);
        check("timer_clear", 32'(cause_o[30]), 32'd0);
`else
        mtc0(8'h58, 32'd5);
        mtc0(8'h48, 32'd7);
        cp0_addr = 8'h58;
        step();
        check("no_timer_cmp", cp0_rdata, 32'd0);
        cp0_addr = 8'h48;
        #1 check("no_timer_cnt", cp0_rdata, 32'd0);
        step();
`endif

        // Random WB traffic with independent flags so priority gets exercised
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) ext_int = ext_int ^ 6'(1 << $urandom_range(0, NHW - 1));
            wb_valid     = ($urandom_range(0, 3) != 0);
            wb_bd        = $urandom_range(0, 1);
            wb_exc       = ($urandom_range(0, 5) == 0);
            wb_exc_code  = code_tab[$urandom_range(0, 5)];
            wb_eret      = ($urandom_range(0, 4) == 0);
            wb_mtc0      = ($urandom_range(0, 2) == 0);
            redirect_ack = ($urandom_range(0, 3) != 0);
            if (wb_mtc0 && $urandom_range(0, 2) == 0) begin
                cp0_addr  = 8'h60;
                cp0_wdata = $urandom & 32'h0000_ff03;
            end
            step();
        end

        // Reset while a redirect is being held
        ext_int = 0;
        mtc0(8'h60, 32'h0);
        step();
        step();
        wb_valid = 1; wb_eret = 1; redirect_ack = 0;
        step();
        check("pre_rst_hold", 32'(redirect_valid), 32'd1);
        #2 reset = 1;
        #1;
        check("rst_hold_rv", 32'(redirect_valid), 32'd0);
        check("rst_hold_status", status_o, 32'h0040_0000);
        check("rst_hold_cause", cause_o, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
